muldiv_unit: RTL and testbench

- Iterative RV32M/RV64M multiply/divide unit, parametrised on XLEN.
- Sits beside the integer ALU in the execute stage.
- Accepts one operation per handshake and decodes funct3 for the M-extension.
- Computes one bit per cycle and returns the result through a valid/ready output handshake. The pipeline stalls on busy.

---
 rtl/muldiv_unit.sv | 129 ++++++++++++
 tb/tb_muldiv_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one bit per cycle, valid/ready on both sides.
// Special divide cases (divide by zero, signed overflow) resolve in the accept cycle.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   hi_q, lo_q, b_q;

    // Accept-cycle decode: operand signedness, magnitudes and special divide cases
    logic              is_div_c, sgn_a_c, sgn_b_c, a_neg_c, b_neg_c, neg_c;
    logic [XLEN-1:0]   a_abs_c, b_abs_c, special_res_c;
    logic              div_zero_c, div_ovf_c, special_c, accept_c;

    always_comb begin
        is_div_c   = funct3[2];
        sgn_a_c    = is_div_c ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
        sgn_b_c    = is_div_c ? ~funct3[0] : (funct3[1:0] == 2'b01);
        a_neg_c    = sgn_a_c & op_a[XLEN-1];
        b_neg_c    = sgn_b_c & op_b[XLEN-1];
        a_abs_c    = a_neg_c ? -op_a : op_a;
        b_abs_c    = b_neg_c ? -op_b : op_b;
        neg_c      = (is_div_c && funct3[1]) ? a_neg_c : (a_neg_c ^ b_neg_c);
        div_zero_c = is_div_c && (op_b == '0);
        div_ovf_c  = is_div_c && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
        special_c  = div_zero_c | div_ovf_c;
        if (div_zero_c) special_res_c = funct3[1] ? op_a : '1;
        else            special_res_c = funct3[1] ? '0 : op_a;
        accept_c   = (state_q == S_IDLE) && in_valid && !kill;
    end

    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);

    // One iteration: shift-add for multiply, restoring shift-subtract for divide
    logic [XLEN:0]     sum_c, rem_sh_c, diff_c;
    logic              ge_c;
    logic [XLEN-1:0]   hi_n_c, lo_n_c, div_val_c, final_c;
    logic [2*XLEN-1:0] prod_c;

    always_comb begin
        sum_c    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        rem_sh_c = {hi_q, lo_q[XLEN-1]};
        diff_c   = rem_sh_c - {1'b0, b_q};
        ge_c     = ~diff_c[XLEN];
        if (op_q[2]) begin
            hi_n_c = ge_c ? diff_c[XLEN-1:0] : rem_sh_c[XLEN-1:0];
            lo_n_c = {lo_q[XLEN-2:0], ge_c};
        end else begin
            hi_n_c = sum_c[XLEN:1];
            lo_n_c = {sum_c[0], lo_q[XLEN-1:1]};
        end
        prod_c    = neg_q ? -{hi_n_c, lo_n_c} : {hi_n_c, lo_n_c};
        div_val_c = op_q[1] ? hi_n_c : lo_n_c;
        if (op_q[2])              final_c = neg_q ? -div_val_c : div_val_c;
        else if (op_q[1:0] == '0) final_c = prod_c[XLEN-1:0];
        else                      final_c = prod_c[2*XLEN-1:XLEN];
    end

    // Next-state logic; kill outranks both input and output handshakes
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept_c) state_d = special_c ? S_DONE : S_CALC;
            S_CALC: begin
                if (kill)                      state_d = S_IDLE;
                else if (cnt_q == CNT_W'(1))   state_d = S_DONE;
            end
            S_DONE: if (kill || out_ready)     state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_d == S_DONE);
            if (accept_c) begin
                op_q  <= funct3;
                neg_q <= neg_c;
                hi_q  <= '0;
                lo_q  <= a_abs_c;
                b_q   <= b_abs_c;
                cnt_q <= CNT_W'(XLEN);
                if (special_c) result <= special_res_c;
            end else if (state_q == S_CALC && !kill) begin
                hi_q  <= hi_n_c;
                lo_q  <= lo_n_c;
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) result <= final_c;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (XLEN=32): results, latency, backpressure, kill, reset.
module tb_muldiv_unit;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready, kill, out_valid, out_ready, busy;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a, op_b, result;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .op_a(op_a), .op_b(op_b), .kill(kill),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op, count edges from accept (inclusive) to out_valid, optionally stall output
    task automatic run_op(input string tag, input logic [2:0] f, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp,
                          input int exp_lat, input int hold);
        int lat;
        logic saw_ready, unstable;
        @(negedge clk);
        funct3 = f; op_a = a; op_b = b; in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
        lat = 1;
        saw_ready = in_ready;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            saw_ready |= in_ready;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, result, exp);
        check({tag, "_in_ready_low"}, saw_ready, 1'b0);
        if (hold > 0) begin
            unstable = 1'b0;
            repeat (hold) begin
                @(posedge clk); #1;
                if (!out_valid || result !== exp || in_ready) unstable = 1'b1;
            end
            check({tag, "_stall_stable"}, unstable, 1'b0);
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, "_handshake"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1;
        funct3 = '0; op_a = '0; op_b = '0;
        #12;
        check("reset_state", {in_ready, out_valid, busy, result}, {3'b100, 32'h0});
        @(negedge clk); rst_n = 1'b1;

        run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0);
        run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0);
        run_op("mulhu",  3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0);
        run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0);
        run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0);
        run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       33, 0);
        run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        33, 0);

        run_op("divu_z", 3'b101, 32'h1234,     32'h0,        32'hFFFFFFFF, 1, 0);
        run_op("remu_z", 3'b111, 32'h1234,     32'h0,        32'h1234,     1, 0);
        run_op("div_z",  3'b100, 32'd5,        32'h0,        32'hFFFFFFFF, 1, 0);
        run_op("rem_z",  3'b110, 32'hFFFFFFFB, 32'h0,        32'hFFFFFFFB, 1, 0);
        run_op("div_ov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
        run_op("rem_ov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1, 0);

        run_op("stall",  3'b111, 32'd100,      32'd7,        32'd2,        33, 10);

        // kill while idle blocks acceptance
        @(negedge clk);
        kill = 1'b1; in_valid = 1'b1; funct3 = 3'b101; op_a = 32'd9; op_b = 32'd3;
        @(posedge clk); #1;
        check("kill_idle_block", {in_ready, busy}, 2'b10);
        @(negedge clk); kill = 1'b0; in_valid = 1'b0;

        // kill mid-calculation
        @(negedge clk);
        funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk); kill = 1'b1;
        @(posedge clk); #1;
        check("kill_calc_idle", {in_ready, busy, out_valid}, 3'b100);
        kill = 1'b0;
        repeat (40) @(posedge clk);
        #1 check("kill_no_result", out_valid, 1'b0);
        run_op("after_kill", 3'b101, 32'd1000, 32'd3, 32'd333, 33, 0);

        // async reset mid-calculation
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("async_reset", {in_ready, out_valid, busy, result}, {3'b100, 32'h0});
        @(negedge clk); rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1 check("reset_no_result", out_valid, 1'b0);
        run_op("after_reset", 3'b000, 32'd5, 32'd6, 32'd30, 33, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
